// File: rtl/spram_fb_pkg.sv
// Shared constants, lane masks and fill FSM encoding for the SPRAM framebuffer.
package spram_fb_pkg;

   localparam int unsigned SPRAM_WORDS = 16384;
   localparam int unsigned SPRAM_AW    = 14;

   // Nibble write masks: lane 0 is the high byte, lane 1 is the low byte.
   localparam logic [3:0] LANE_HI_MASK = 4'b1100;
   localparam logic [3:0] LANE_LO_MASK = 4'b0011;
   localparam logic [3:0] FULL_MASK    = 4'b1111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fb_state_t;

   function automatic logic [3:0] lane_mask(input logic lane);
      return lane ? LANE_LO_MASK : LANE_HI_MASK;
   endfunction

endpackage

// File: rtl/spram_bank.sv
// One 16K x 16 SPRAM macro. Hardware builds use the iCE40UP primitive; simulation
// and DEBUG builds use a behavioural array with per-nibble masking and 1-cycle read.
module spram_bank
   import spram_fb_pkg::*;
(
   input  logic                clk,
   input  logic [SPRAM_AW-1:0] addr,
   input  logic [15:0]         din,
   input  logic [3:0]          mask,
   input  logic                we,
   output logic [15:0]         dout
);

`ifdef SYNTHESIS
`ifndef DEBUG
   SB_SPRAM256KA u_spram (
      .ADDRESS    (addr),
      .DATAIN     (din),
      .MASKWREN   (mask),
      .WREN       (we),
      .CHIPSELECT (1'b1),
      .CLOCK      (clk),
      .STANDBY    (1'b0),
      .SLEEP      (1'b0),
      .POWEROFF   (1'b1),
      .DATAOUT    (dout)
   );
`else
   logic [15:0] r_mem [SPRAM_WORDS];
   logic [15:0] r_dout;

   // Masked nibble writes; read data is registered and only refreshed on non-write cycles.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned n = 0; n < 4; n++) begin
            if (mask[n]) r_mem[addr][n*4 +: 4] <= din[n*4 +: 4];
         end
      end else begin
         r_dout <= r_mem[addr];
      end
   end

   assign dout = r_dout;
`endif
`else
   logic [15:0] r_mem [SPRAM_WORDS];
   logic [15:0] r_dout;

   // Masked nibble writes; read data is registered and only refreshed on non-write cycles.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned n = 0; n < 4; n++) begin
            if (mask[n]) r_mem[addr][n*4 +: 4] <= din[n*4 +: 4];
         end
      end else begin
         r_dout <= r_mem[addr];
      end
   end

   assign dout = r_dout;
`endif

endmodule

// File: rtl/spram_framebuffer.sv
// Byte-addressable framebuffer over NUM_BANKS SPRAM macros with lane-masked writes,
// 1-cycle registered reads, out-of-range protection and a whole-memory fill engine.
module spram_framebuffer
   import spram_fb_pkg::*;
#(
   parameter int unsigned NUM_BANKS  = 3,
   parameter int unsigned ADDR_WIDTH = 17,
   parameter int unsigned DEPTH      = 76800
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [7:0]            wdata,
   input  logic                  w_enable,
   input  logic                  r_enable,
   output logic                  ready,
   output logic [7:0]            rdata,
   output logic                  rdata_valid,
   input  logic                  fill_start,
   input  logic [7:0]            fill_value,
   output logic                  fill_busy
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   fb_state_t             r_state;
   fb_state_t             w_state_nx;
   logic [SPRAM_AW-1:0]   r_fill_cnt;
   logic [7:0]            r_fill_val;

   logic                  w_in_range;
   logic [ADDR_WIDTH-1:0] w_bank;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_fill_we;

   logic                  r_rd_valid;
   logic [ADDR_WIDTH-1:0] r_rd_bank;
   logic                  r_rd_lane;
   logic                  r_rd_oor;
   logic [7:0]            r_rdata;
   logic [15:0]           w_rd_word;
   logic [7:0]            w_rd_byte;
   logic [15:0]           w_dout [NUM_BANKS];

   assign w_in_range = ({1'b0, addr} < DEPTH_W);
   assign w_bank     = addr >> (SPRAM_AW + 1);
   assign ready      = (r_state == ST_IDLE);
   assign fill_busy  = (r_state == ST_FILL);
   assign w_wr_acc   = ready && w_enable && w_in_range;
   assign w_rd_acc   = ready && r_enable && !w_enable;
   assign w_fill_we  = (r_state == ST_FILL) && !reset;

   // Fill FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nx;
   end

   // Fill FSM next state: start on fill_start, finish after the last word is written.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE: if (fill_start) w_state_nx = ST_FILL;
         ST_FILL: if (r_fill_cnt == '1) w_state_nx = ST_IDLE;
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // Fill word counter and latched fill byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fill_cnt <= '0;
         r_fill_val <= '0;
      end else if (r_state == ST_IDLE) begin
         if (fill_start) begin
            r_fill_cnt <= '0;
            r_fill_val <= fill_value;
         end
      end else begin
         r_fill_cnt <= r_fill_cnt + 1'b1;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic                w_we;
      logic [SPRAM_AW-1:0] w_addr;
      logic [15:0]         w_din;
      logic [3:0]          w_mask;

      // Bank port mux: the fill engine drives every bank, otherwise only the addressed bank writes.
      always_comb begin
         w_we   = 1'b0;
         w_addr = addr[SPRAM_AW:1];
         w_din  = {wdata, wdata};
         w_mask = lane_mask(addr[0]);
         if (w_fill_we) begin
            w_we   = 1'b1;
            w_addr = r_fill_cnt;
            w_din  = {r_fill_val, r_fill_val};
            w_mask = FULL_MASK;
         end else if (w_wr_acc && (w_bank == ADDR_WIDTH'(b))) begin
            w_we = 1'b1;
         end
      end

      spram_bank u_bank (
         .clk  (clk),
         .addr (w_addr),
         .din  (w_din),
         .mask (w_mask),
         .we   (w_we),
         .dout (w_dout[b])
      );
   end

   // Read bookkeeping: remember bank/lane of an accepted read, hold the last returned byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_bank  <= '0;
         r_rd_lane  <= 1'b0;
         r_rd_oor   <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_bank <= w_bank;
            r_rd_lane <= addr[0];
            r_rd_oor  <= !w_in_range;
         end
         if (r_rd_valid) r_rdata <= w_rd_byte;
      end
   end

   // Select the returned byte from the registered bank/lane; out-of-range reads return zero.
   always_comb begin
      w_rd_word = '0;
      w_rd_byte = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (r_rd_bank == ADDR_WIDTH'(b)) w_rd_word = w_dout[b];
      end
      if (!r_rd_oor) w_rd_byte = r_rd_lane ? w_rd_word[7:0] : w_rd_word[15:8];
   end

   // The SPRAM output is itself the read register, so the valid cycle passes it
   // straight through and r_rdata only holds it afterwards.
   assign rdata       = r_rd_valid ? w_rd_byte : r_rdata;
   assign rdata_valid = r_rd_valid;

endmodule

// File: tb/tb_spram_framebuffer.sv
// Directed self-checking bench for spram_framebuffer.
module tb_spram_framebuffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [16:0] addr;
   logic [7:0]  wdata;
   logic        w_enable;
   logic        r_enable;
   logic        ready;
   logic [7:0]  rdata;
   logic        rdata_valid;
   logic        fill_start;
   logic [7:0]  fill_value;
   logic        fill_busy;

   int n_tests = 0;
   int n_fail  = 0;

   spram_framebuffer #(
      .NUM_BANKS  (3),
      .ADDR_WIDTH (17),
      .DEPTH      (76800)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .addr        (addr),
      .wdata       (wdata),
      .w_enable    (w_enable),
      .r_enable    (r_enable),
      .ready       (ready),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .fill_start  (fill_start),
      .fill_value  (fill_value),
      .fill_busy   (fill_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [16:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; wdata = d; w_enable = 1'b1;
      @(posedge clk); #1;
      w_enable = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [16:0] a, input logic [7:0] exp);
      @(negedge clk);
      addr = a; r_enable = 1'b1;
      check({tag, "_idle_valid"}, 32'(rdata_valid), 32'd0);
      @(posedge clk); #1;
      r_enable = 1'b0;
      check({tag, "_valid"}, 32'(rdata_valid), 32'd1);
      check({tag, "_data"}, 32'(rdata), 32'(exp));
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, 32'(rdata_valid), 32'd0);
      check({tag, "_hold"}, 32'(rdata), 32'(exp));
   endtask

   task automatic start_fill(input logic [7:0] v);
      @(negedge clk);
      fill_start = 1'b1; fill_value = v;
      @(posedge clk); #1;
      fill_start = 1'b0; fill_value = 8'h00;
   endtask

   // Called at posedge+1 right after fill_start was accepted; counts busy cycles
   // and pokes host accesses that must be ignored.
   task automatic watch_fill(output int cyc, output logic ready_ok, output logic no_valid);
      cyc = 0; ready_ok = 1'b1; no_valid = 1'b1;
      while (fill_busy === 1'b1 && cyc < 20000) begin
         cyc++;
         if (ready !== 1'b0) ready_ok = 1'b0;
         if (rdata_valid !== 1'b0) no_valid = 1'b0;
         case (cyc)
            50: begin addr = 17'd0; wdata = 8'h99; w_enable = 1'b1; end
            51: w_enable = 1'b0;
            60: begin addr = 17'd40000; r_enable = 1'b1; end
            61: r_enable = 1'b0;
            default: ;
         endcase
         @(posedge clk); #1;
      end
   endtask

   int   cyc;
   logic rdy_ok;
   logic nv_ok;

   initial begin
      reset = 1'b1; addr = '0; wdata = '0; w_enable = 1'b0; r_enable = 1'b0;
      fill_start = 1'b0; fill_value = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_valid", 32'(rdata_valid), 32'd0);
      check("rst_busy",  32'(fill_busy), 32'd0);
      reset = 1'b0;

      // Both lanes of word 0
      do_write(17'h00000, 8'hA5);
      do_write(17'h00001, 8'h3C);
      do_read("rd_lane0", 17'h00000, 8'hA5);
      do_read("rd_lane1", 17'h00001, 8'h3C);

      // Bank boundaries
      do_write(17'h07FFF, 8'h11);
      do_write(17'h08000, 8'h22);
      do_write(17'h12BFF, 8'h33);
      do_read("rd_b0_top", 17'h07FFF, 8'h11);
      do_read("rd_b1_bot", 17'h08000, 8'h22);
      do_read("rd_b2_last", 17'h12BFF, 8'h33);

      // Out of range
      do_write(17'd76800, 8'h77);
      do_read("rd_oor", 17'd76800, 8'h00);
      do_read("rd_zero_kept", 17'h00000, 8'hA5);

      // Collision: write wins, no read strobe
      @(negedge clk);
      addr = 17'd2; wdata = 8'h44; w_enable = 1'b1; r_enable = 1'b1;
      @(posedge clk); #1;
      w_enable = 1'b0; r_enable = 1'b0;
      check("coll_no_valid", 32'(rdata_valid), 32'd0);
      @(posedge clk); #1;
      check("coll_no_valid2", 32'(rdata_valid), 32'd0);
      do_read("coll_wr_done", 17'd2, 8'h44);

      // Full fill
      check("pre_fill_ready", 32'(ready), 32'd1);
      start_fill(8'h5A);
      check("fill_busy_on", 32'(fill_busy), 32'd1);
      watch_fill(cyc, rdy_ok, nv_ok);
      check("fill_cycles", 32'(cyc), 32'd16384);
      check("fill_ready_low", 32'(rdy_ok), 32'd1);
      check("fill_no_rd_valid", 32'(nv_ok), 32'd1);
      check("fill_done_ready", 32'(ready), 32'd1);
      do_read("fill_rd_0", 17'd0, 8'h5A);
      do_read("fill_rd_40000", 17'd40000, 8'h5A);
      do_read("fill_rd_76799", 17'd76799, 8'h5A);

      // Reset during fill, then restart
      start_fill(8'hE1);
      repeat (99) @(posedge clk);
      #1;
      check("abort_busy_before", 32'(fill_busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", 32'(fill_busy), 32'd0);
      check("abort_ready", 32'(ready), 32'd1);
      start_fill(8'hC3);
      check("refill_busy", 32'(fill_busy), 32'd1);
      watch_fill(cyc, rdy_ok, nv_ok);
      check("refill_cycles", 32'(cyc), 32'd16384);
      do_read("refill_rd_0", 17'd0, 8'hC3);
      do_read("refill_rd_76799", 17'd76799, 8'hC3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
